// File: rtl/i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// i2c_slave_regs
// I2C target with 7-bit addressing that oversamples SCL/SDA in the system
// clock domain. The bus protocol maps onto a byte-wide register-file port:
// a pointer byte follows the address. Writes and reads then auto-increment
// the pointer. Repeated START and an open-drain SDA driver are supported.
//
// Ports
//   clk, rst_n   system clock (>= 16x SCL), asynchronous active-low reset
//   slave_addr   own 7-bit address, captured at every START
//   scl_i, sda_i raw pad inputs (synchronised internally)
//   sda_oe       1 = pull SDA low, 0 = release
//   reg_addr     current register pointer
//   reg_wdata    write data, qualified by reg_we
//   reg_we       one-clk write strobe
//   reg_re       one-clk read strobe; reg_rdata is expected one clk later
//   reg_rdata    read data from the register bank
//   busy         high from own-address ACK until STOP/START
// ---------------------------------------------------------------------------
module i2c_slave_regs #(
  parameter int REG_DEPTH   = 16,
  parameter int PTR_W       = $clog2(REG_DEPTH),
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       slave_addr,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  output logic             reg_re,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(REG_DEPTH - 1);
  localparam logic [8:0]       DEPTH_LIM = 9'(REG_DEPTH);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  state_t           state, state_n;
  logic [3:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shift, shift_n;
  logic [6:0]       tx, tx_n;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic [6:0]       own_addr, own_addr_n;
  logic             rw, rw_n;
  logic             mack, mack_n;
  logic             re_d;
  logic             sda_oe_n, busy_n, we_n, re_n;
  logic [7:0]       wdata_n;

  // Pad synchronisers followed by one edge-detect stage. Reset to the idle
  // bus level so that leaving reset does not fabricate a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  // Bus events. START/STOP only need SCL high now, so an SDA edge that lands
  // in the same cycle as an SCL rise is still treated as a bus condition.
  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  assign ptr_inc  = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
  assign reg_addr = ptr;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      ptr       <= '0;
      own_addr  <= '0;
      rw        <= 1'b0;
      mack      <= 1'b1;
      re_d      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      reg_wdata <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      tx        <= tx_n;
      ptr       <= ptr_n;
      own_addr  <= own_addr_n;
      rw        <= rw_n;
      mack      <= mack_n;
      re_d      <= reg_re;
      sda_oe    <= sda_oe_n;
      busy      <= busy_n;
      reg_we    <= we_n;
      reg_re    <= re_n;
      reg_wdata <= wdata_n;
    end
  end

  // Next-state logic. Received bits shift in on SCL rise. The SDA driver
  // only moves on SCL fall, except for the first bit of a read byte. That
  // bit is driven once the bank data arrives, two clks after the read
  // strobe and still well inside the SCL low phase.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_n       = tx;
    ptr_n      = ptr;
    own_addr_n = own_addr;
    rw_n       = rw;
    mack_n     = mack;
    sda_oe_n   = sda_oe;
    busy_n     = busy;
    we_n       = 1'b0;
    re_n       = 1'b0;
    wdata_n    = reg_wdata;

    if (start_det) begin
      state_n    = ADDR;
      bit_cnt_n  = '0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
      own_addr_n = slave_addr;
    end else if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if (shift[7:1] == own_addr) begin
              state_n  = ADDR_ACK;
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
              rw_n     = shift[0];
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (rw) begin
              state_n = RDATA;
              re_n    = 1'b1;
            end else begin
              state_n = PTR;
            end
          end
        end
        PTR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            if ({1'b0, shift} < DEPTH_LIM) begin
              ptr_n    = shift[PTR_W-1:0];
              sda_oe_n = 1'b1;
              state_n  = PTR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        PTR_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            state_n   = WDATA;
          end
        end
        WDATA: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              wdata_n = {shift[6:0], sda_s};
              we_n    = 1'b1;
            end
          end else if (scl_fall && bit_cnt == 4'd8) begin
            sda_oe_n = 1'b1;
            state_n  = WDATA_ACK;
          end
        end
        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            ptr_n     = ptr_inc;
            state_n   = WDATA;
          end
        end
        RDATA: begin
          // tx keeps only the bits not yet on the wire; MSB goes straight out.
          if (re_d) begin
            tx_n      = reg_rdata[6:0];
            sda_oe_n  = ~reg_rdata[7];
            bit_cnt_n = '0;
          end else if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_n = 1'b0;
              state_n  = RDATA_ACK;
            end else begin
              sda_oe_n = ~tx[6];
              tx_n     = {tx[5:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            mack_n = sda_s;
          end else if (scl_fall) begin
            if (!mack) begin
              ptr_n     = ptr_inc;
              re_n      = 1'b1;
              bit_cnt_n = '0;
              state_n   = RDATA;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_regs
// Bit-banged I2C master driving i2c_slave_regs with directed and randomised
// transactions. A transaction-level model of the target's pointer and
// register contents predicts register strobes and bus responses. These go
// into scoreboard queues that a monitor drains as the DUT produces events.
// ---------------------------------------------------------------------------
module tb_i2c_slave_regs;

  localparam int REG_DEPTH = 16;
  localparam int PTR_W     = 4;
  localparam int QTR       = 8;
  localparam int HALF      = 16;
  localparam logic [6:0] SLAVE = 7'h42;

  typedef struct {
    int kind;
    int val;
  } bus_ev_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             scl_m = 1'b1;
  logic             sda_m = 1'b1;
  logic             sda_bus;
  logic             sda_oe;
  logic [PTR_W-1:0] reg_addr;
  logic [7:0]       reg_wdata;
  logic             reg_we;
  logic             reg_re;
  logic [7:0]       reg_rdata;
  logic             busy;

  logic [7:0] bank_mem   [REG_DEPTH];
  logic [7:0] model_bank [REG_DEPTH];
  int         model_ptr = 0;
  logic [7:0] wr_q [$];
  int         exp_reg [$];
  bus_ev_t    exp_bus [$];
  bus_ev_t    act_bus [$];
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regs #(.REG_DEPTH(REG_DEPTH), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .slave_addr (SLAVE),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .busy       (busy)
  );

  // Register bank behind the DUT: registered read, data valid the clk after reg_re.
  always @(posedge clk) begin
    if (reg_we) bank_mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= bank_mem[reg_addr];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int make_ev(input int kind, input int addr, input int data);
    return (kind << 16) | (addr << 8) | data;
  endfunction

  function automatic bus_ev_t mk_bus(input int kind, input int val);
    bus_ev_t b;
    b.kind = kind;
    b.val  = val;
    return b;
  endfunction

  // Monitor: pops the scoreboard whenever a register strobe or bus observation appears.
  always @(negedge clk) begin
    int act;
    bus_ev_t a, e;
    if (reg_we || reg_re) begin
      act = make_ev((reg_we ? 2 : 0) | (reg_re ? 1 : 0), int'(reg_addr),
                    reg_we ? int'(reg_wdata) : 0);
      if (exp_reg.size() == 0) checkOutput("unexpected_reg_strobe", act, 0);
      else checkOutput("reg_event", act, exp_reg.pop_front());
    end
    while (act_bus.size() > 0) begin
      a = act_bus.pop_front();
      if (exp_bus.size() == 0) checkOutput("unexpected_bus_event", a.kind * 256 + a.val, -1);
      else begin
        e = exp_bus.pop_front();
        checkOutput(e.kind == 1 ? "read_byte" : "ack_bit", a.kind * 256 + a.val,
                    e.kind * 256 + e.val);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    sda_m = b;
    wait_clk(QTR);
    scl_m = 1'b1;
    wait_clk(QTR);
    s = sda_bus;
    wait_clk(QTR);
    scl_m = 1'b0;
    wait_clk(QTR);
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_clk(QTR);
    scl_m = 1'b1;
    wait_clk(QTR);
    sda_m = 1'b0;
    wait_clk(QTR);
    scl_m = 1'b0;
    wait_clk(QTR);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    wait_clk(QTR);
    scl_m = 1'b1;
    wait_clk(QTR);
    sda_m = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, s);
    act_bus.push_back(mk_bus(0, int'(s)));
  endtask

  task automatic recv_byte(input logic master_ack);
    logic s;
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      v = {v[6:0], s};
    end
    act_bus.push_back(mk_bus(1, int'(v)));
    bus_bit(master_ack, s);
  endtask

  // Write transaction: address, pointer, then the bytes queued in wr_q.
  task automatic write_txn(input logic [7:0] addr_byte, input int ptr_val, input bit do_stop);
    bit addr_ok, ptr_ok;
    addr_ok = (addr_byte[7:1] == SLAVE) && !addr_byte[0];
    ptr_ok  = 1'b0;
    exp_bus.push_back(mk_bus(0, addr_ok ? 0 : 1));
    start_cond();
    send_byte(addr_byte);
    if (addr_ok) begin
      ptr_ok = (ptr_val < REG_DEPTH);
      exp_bus.push_back(mk_bus(0, ptr_ok ? 0 : 1));
      send_byte(8'(ptr_val));
      if (ptr_ok) begin
        model_ptr = ptr_val;
        foreach (wr_q[i]) begin
          exp_reg.push_back(make_ev(2, model_ptr, int'(wr_q[i])));
          model_bank[model_ptr] = wr_q[i];
          model_ptr = (model_ptr + 1) % REG_DEPTH;
          exp_bus.push_back(mk_bus(0, 0));
          send_byte(wr_q[i]);
        end
      end
    end
    checkOutput("busy_in_txn", int'(busy), int'(addr_ok));
    if (do_stop || !addr_ok || !ptr_ok) begin
      stop_cond();
      checkOutput("busy_after_stop", int'(busy), 0);
    end
    wr_q.delete();
  endtask

  // Read transaction from the current pointer; master ACKs all but the last byte.
  task automatic read_txn(input int n);
    int p;
    p = model_ptr;
    exp_bus.push_back(mk_bus(0, 0));
    for (int k = 0; k < n; k++) begin
      exp_reg.push_back(make_ev(1, p, 0));
      exp_bus.push_back(mk_bus(1, int'(model_bank[p])));
      if (k < n - 1) p = (p + 1) % REG_DEPTH;
    end
    model_ptr = p;
    start_cond();
    send_byte({SLAVE, 1'b1});
    for (int k = 0; k < n; k++) recv_byte(k < n - 1 ? 1'b0 : 1'b1);
    checkOutput("busy_read", int'(busy), 1);
    checkOutput("sda_released_after_nack", int'(sda_oe), 0);
    stop_cond();
    checkOutput("busy_after_read_stop", int'(busy), 0);
  endtask

  // One random transaction: write, pointer+read, read from pointer, or foreign address.
  task automatic applyStimulus();
    int r, n, p;
    logic [6:0] bad;
    r = $urandom_range(0, 9);
    n = $urandom_range(1, 4);
    wr_q.delete();
    if (r < 4) begin
      p = $urandom_range(0, REG_DEPTH + 1);
      repeat (n) wr_q.push_back(8'($urandom));
      write_txn(8'h84, p, 1'b1);
    end else if (r < 8) begin
      p = $urandom_range(0, REG_DEPTH - 1);
      write_txn(8'h84, p, 1'b0);
      read_txn(n);
    end else if (r == 8) begin
      read_txn(n);
    end else begin
      bad = 7'($urandom);
      if (bad == SLAVE) bad = bad ^ 7'h01;
      write_txn({bad, 1'($urandom)}, 0, 1'b1);
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic s;
    for (int i = 0; i < REG_DEPTH; i++) model_bank[i] = '0;

    wait_clk(5);
    checkOutput("reset_sda_oe", int'(sda_oe), 0);
    checkOutput("reset_reg_we", int'(reg_we), 0);
    checkOutput("reset_reg_re", int'(reg_re), 0);
    checkOutput("reset_reg_addr", int'(reg_addr), 0);
    checkOutput("reset_reg_wdata", int'(reg_wdata), 0);
    checkOutput("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    wait_clk(10);

    // Fill every register; the pointer wraps from 15 back to 0.
    for (int i = 0; i < REG_DEPTH; i++) wr_q.push_back(8'($urandom));
    write_txn(8'h84, 0, 1'b1);

    wr_q = '{8'hA5, 8'h5A};
    write_txn(8'h84, 3, 1'b1);

    wr_q = '{8'h11, 8'h22, 8'h33};
    write_txn(8'h84, 2, 1'b1);
    write_txn(8'h84, 2, 1'b0);
    read_txn(3);

    write_txn(8'h86, 0, 1'b1);

    write_txn(8'h84, 16, 1'b1);
    wr_q = '{8'hC1, 8'hC2};
    write_txn(8'h84, 15, 1'b1);

    // STOP after half a data byte must not produce a write.
    exp_bus.push_back(mk_bus(0, 0));
    exp_bus.push_back(mk_bus(0, 0));
    start_cond();
    send_byte(8'h84);
    send_byte(8'h05);
    model_ptr = 5;
    for (int i = 0; i < 4; i++) bus_bit(i[0], s);
    stop_cond();
    checkOutput("sda_oe_after_early_stop", int'(sda_oe), 0);
    checkOutput("busy_after_early_stop", int'(busy), 0);

    // Reset in the middle of a read byte while the target pulls SDA low.
    wr_q = '{8'h00};
    write_txn(8'h84, 7, 1'b1);
    write_txn(8'h84, 7, 1'b0);
    exp_bus.push_back(mk_bus(0, 0));
    exp_reg.push_back(make_ev(1, 7, 0));
    start_cond();
    send_byte({SLAVE, 1'b1});
    bus_bit(1'b1, s);
    checkOutput("read_bit_pre_reset", int'(s), int'(model_bank[7][7]));
    wait_clk(2);
    checkOutput("sda_oe_before_reset", int'(sda_oe), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("sda_oe_in_reset", int'(sda_oe), 0);
    checkOutput("reg_addr_in_reset", int'(reg_addr), 0);
    checkOutput("busy_in_reset", int'(busy), 0);
    model_ptr = 0;
    sda_m = 1'b1;
    scl_m = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    wr_q = '{8'h3C};
    write_txn(8'h84, 1, 1'b1);
    read_txn(2);

    for (int t = 0; t < 16; t++) applyStimulus();

    wait_clk(50);
    checkOutput("exp_reg_leftover", exp_reg.size(), 0);
    checkOutput("exp_bus_leftover", exp_bus.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
